// File: rtl/pellet_score_engine_if.sv
// Bus between the sprite/host side and the pellet score engine.
// Carries map load, sprite positions, render query and game status.
interface pellet_score_engine_if #(
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int NUM_GHOSTS = 4,
  parameter int SCORE_W    = 16
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic                  start;
  logic                  ack;
  logic                  init_we;
  logic [CW-1:0]         init_col;
  logic [RW-1:0]         init_row;
  logic [1:0]            init_kind;
  logic [9:0]            pacX;
  logic [9:0]            pacY;
  logic [NUM_GHOSTS-1:0] ghost_hit;
  logic [9:0]            hCount;
  logic [9:0]            vCount;
  logic [1:0]            pellet_kind;
  logic [SCORE_W-1:0]    score;
  logic [1:0]            lives;
  logic [11:0]           pellets_left;
  logic                  frightened;
  logic [NUM_GHOSTS-1:0] ghost_eaten;
  logic                  pac_respawn;
  logic                  winOut;
  logic                  loseOut;

  modport master (
    output start, ack, init_we, init_col, init_row, init_kind,
    output pacX, pacY, ghost_hit, hCount, vCount,
    input  pellet_kind, score, lives, pellets_left, frightened,
    input  ghost_eaten, pac_respawn, winOut, loseOut
  );

  modport slave (
    input  start, ack, init_we, init_col, init_row, init_kind,
    input  pacX, pacY, ghost_hit, hCount, vCount,
    output pellet_kind, score, lives, pellets_left, frightened,
    output ghost_eaten, pac_respawn, winOut, loseOut
  );
endinterface

// File: rtl/pellet_score_engine.sv
// Tile-map pellet scoring, power mode, lives and win/lose control
// for the Pacman datapath.
module pellet_score_engine #(
  parameter int COLS           = 40,
  parameter int ROWS           = 30,
  parameter int TILE_SHIFT     = 4,
  parameter int NUM_GHOSTS     = 4,
  parameter int SCORE_W        = 16,
  parameter int PELLET_PTS     = 10,
  parameter int POWER_PTS      = 50,
  parameter int GHOST_PTS      = 200,
  parameter int POWER_CYCLES   = 2**24,
  parameter int RESPAWN_CYCLES = 2**23,
  parameter int START_LIVES    = 3
) (
  input logic                  clk,
  input logic                  reset,
  pellet_score_engine_if.slave bus
);
  localparam int NT = COLS * ROWS;
  localparam int IW = (NT > 1) ? $clog2(NT) : 1;
  localparam int TW = $clog2(POWER_CYCLES + 1);
  localparam int DW = $clog2(RESPAWN_CYCLES + 1);
  localparam logic [SCORE_W-1:0] SMAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_PLAY, S_DYING, S_WIN, S_LOSE
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            map_q [NT];
  logic [1:0]            map_d [NT];
  logic [11:0]           left_q, left_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [1:0]            lives_q, lives_d;
  logic                  fright_q, fright_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [DW-1:0]         resp_q, resp_d;
  logic [1:0]            combo_q, combo_d;
  logic [NUM_GHOSTS-1:0] eaten_q, eaten_d;
  logic [NUM_GHOSTS-1:0] ge_q, ge_d;
  logic                  rsp_q, rsp_d;
  logic                  start_q, start_d;

  logic          wr_ok, pac_ok, found;
  logic [IW-1:0] wr_idx, pac_idx;
  logic [1:0]    wr_kind, old_kind, cur_kind;
  logic [31:0]   add;
  logic [32:0]   sum;

  function automatic logic in_map(input logic [9:0] x,
                                  input logic [9:0] y);
    return (int'(x >> TILE_SHIFT) < COLS) &&
           (int'(y >> TILE_SHIFT) < ROWS);
  endfunction

  function automatic logic [IW-1:0] pix_idx(input logic [9:0] x,
                                            input logic [9:0] y);
    return IW'(int'(y >> TILE_SHIFT) * COLS + int'(x >> TILE_SHIFT));
  endfunction

  always_comb begin
    bus.pellet_kind = 2'd0;
    if (in_map(bus.hCount, bus.vCount))
      bus.pellet_kind = map_q[pix_idx(bus.hCount, bus.vCount)];
  end

  always_comb begin
    state_d  = state_q;
    map_d    = map_q;
    left_d   = left_q;
    score_d  = score_q;
    lives_d  = lives_q;
    fright_d = fright_q;
    timer_d  = timer_q;
    resp_d   = resp_q;
    combo_d  = combo_q;
    eaten_d  = eaten_q;
    ge_d     = '0;
    rsp_d    = 1'b0;
    start_d  = bus.start;
    found    = 1'b0;
    add      = 32'd0;
    sum      = 33'd0;

    wr_ok    = (int'(bus.init_col) < COLS) &&
               (int'(bus.init_row) < ROWS);
    wr_idx   = IW'(int'(bus.init_row) * COLS + int'(bus.init_col));
    wr_kind  = (bus.init_kind == 2'd3) ? 2'd0 : bus.init_kind;
    old_kind = map_q[wr_idx];
    pac_ok   = in_map(bus.pacX, bus.pacY);
    pac_idx  = pix_idx(bus.pacX, bus.pacY);
    cur_kind = pac_ok ? map_q[pac_idx] : 2'd0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.init_we && wr_ok) begin
          map_d[wr_idx] = wr_kind;
          if (old_kind == 2'd0 && wr_kind != 2'd0)
            left_d = left_q + 12'd1;
          else if (old_kind != 2'd0 && wr_kind == 2'd0)
            left_d = left_q - 12'd1;
        end
        // Rising edge only, so a start held across ack cannot relaunch
        if (bus.start && !start_q) begin
          state_d  = S_PLAY;
          score_d  = '0;
          lives_d  = 2'(START_LIVES);
          fright_d = 1'b0;
          timer_d  = '0;
          combo_d  = 2'd0;
          eaten_d  = '0;
        end
      end
      S_PLAY: begin
        if (left_q == 12'd0) begin
          state_d = S_WIN;
        end else if (|bus.ghost_hit && !fright_q) begin
          lives_d  = lives_q - 2'd1;
          rsp_d    = 1'b1;
          fright_d = 1'b0;
          timer_d  = '0;
          combo_d  = 2'd0;
          eaten_d  = '0;
          if (lives_q == 2'd1) begin
            state_d = S_LOSE;
          end else begin
            state_d = S_DYING;
            resp_d  = DW'(RESPAWN_CYCLES);
          end
        end else begin
          if (fright_q) begin
            if (timer_q > TW'(1)) begin
              timer_d = timer_q - TW'(1);
            end else begin
              timer_d  = '0;
              fright_d = 1'b0;
              eaten_d  = '0;
            end
            for (int i = 0; i < NUM_GHOSTS; i++) begin
              if (!found && bus.ghost_hit[i] && !eaten_q[i]) begin
                found      = 1'b1;
                ge_d[i]    = 1'b1;
                eaten_d[i] = 1'b1;
              end
            end
            if (found) begin
              add = 32'(GHOST_PTS) << combo_q;
              if (combo_q != 2'd3)
                combo_d = combo_q + 2'd1;
            end
          end
          if (cur_kind != 2'd0) begin
            map_d[pac_idx] = 2'd0;
            left_d = left_q - 12'd1;
            if (cur_kind == 2'd2) begin
              add      = add + 32'(POWER_PTS);
              fright_d = 1'b1;
              timer_d  = TW'(POWER_CYCLES);
              combo_d  = 2'd0;
              eaten_d  = '0;
            end else begin
              add = add + 32'(PELLET_PTS);
            end
          end
          sum = 33'(score_q) + {1'b0, add};
          score_d = (sum > 33'(SMAX)) ? SMAX : sum[SCORE_W-1:0];
        end
      end
      S_DYING: begin
        if (resp_q <= DW'(1)) begin
          resp_d  = '0;
          state_d = S_PLAY;
        end else begin
          resp_d = resp_q - DW'(1);
        end
      end
      S_WIN, S_LOSE: begin
        if (bus.ack)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < NT; i++)
        map_q[i] <= 2'd0;
      left_q   <= '0;
      score_q  <= '0;
      lives_q  <= '0;
      fright_q <= 1'b0;
      timer_q  <= '0;
      resp_q   <= '0;
      combo_q  <= '0;
      eaten_q  <= '0;
      ge_q     <= '0;
      rsp_q    <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      map_q    <= map_d;
      left_q   <= left_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      fright_q <= fright_d;
      timer_q  <= timer_d;
      resp_q   <= resp_d;
      combo_q  <= combo_d;
      eaten_q  <= eaten_d;
      ge_q     <= ge_d;
      rsp_q    <= rsp_d;
      start_q  <= start_d;
    end
  end

  assign bus.score        = score_q;
  assign bus.lives        = lives_q;
  assign bus.pellets_left = left_q;
  assign bus.frightened   = fright_q;
  assign bus.ghost_eaten  = ge_q;
  assign bus.pac_respawn  = rsp_q;
  assign bus.winOut       = (state_q == S_WIN);
  assign bus.loseOut      = (state_q == S_LOSE);
endmodule

// File: tb/tb_pellet_score_engine.sv
// Directed bench for pellet_score_engine: table of per-cycle vectors
// plus hand sequences for timer length, reset and score saturation.
module tb_pellet_score_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pellet_score_engine_if #(.COLS(4), .ROWS(4), .NUM_GHOSTS(4),
                           .SCORE_W(16)) ba ();
  pellet_score_engine_if #(.COLS(8), .ROWS(2), .NUM_GHOSTS(4),
                           .SCORE_W(8)) bb ();

  pellet_score_engine #(
    .COLS(4), .ROWS(4), .TILE_SHIFT(4), .NUM_GHOSTS(4),
    .SCORE_W(16), .PELLET_PTS(10), .POWER_PTS(50), .GHOST_PTS(200),
    .POWER_CYCLES(40), .RESPAWN_CYCLES(5), .START_LIVES(3)
  ) dut_a (.clk(clk), .reset(rst_n), .bus(ba.slave));

  pellet_score_engine #(
    .COLS(8), .ROWS(2), .TILE_SHIFT(4), .NUM_GHOSTS(4),
    .SCORE_W(8), .PELLET_PTS(10), .POWER_PTS(50), .GHOST_PTS(200),
    .POWER_CYCLES(40), .RESPAWN_CYCLES(5), .START_LIVES(3)
  ) dut_b (.clk(clk), .reset(rst_n), .bus(bb.slave));

  typedef struct {
    int st; int ak; int col; int row; int gh;
    int score; int left; int lives; int fr; int ge;
    int rsp; int win; int lose; int pk;
  } vec_t;

  vec_t tbl [64];
  int   nv = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_opt(input string nm, input int act, input int exp);
    if (exp >= 0) chk(nm, act, exp);
  endtask

  task automatic v(input int st, ak, col, row, gh, score, left,
                   lives, fr, ge, rsp, win, lose, pk);
    tbl[nv] = '{st, ak, col, row, gh, score, left,
                lives, fr, ge, rsp, win, lose, pk};
    nv++;
  endtask

  task automatic wr_a(input int col, input int row, input int kind);
    ba.init_we   = 1'b1;
    ba.init_col  = 2'(col);
    ba.init_row  = 2'(row);
    ba.init_kind = 2'(kind);
    step();
    ba.init_we   = 1'b0;
  endtask

  task automatic wr_b(input int col, input int row, input int kind);
    bb.init_we   = 1'b1;
    bb.init_col  = 3'(col);
    bb.init_row  = 1'(row);
    bb.init_kind = 2'(kind);
    step();
    bb.init_we   = 1'b0;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ba.start     = tbl[i].st[0];
      ba.ack       = tbl[i].ak[0];
      ba.pacX      = 10'(tbl[i].col * 16 + 5);
      ba.pacY      = 10'(tbl[i].row * 16 + 3);
      ba.hCount    = ba.pacX;
      ba.vCount    = ba.pacY;
      ba.ghost_hit = 4'(tbl[i].gh);
      step();
      chk_opt($sformatf("v%0d.score", i), int'(ba.score), tbl[i].score);
      chk_opt($sformatf("v%0d.left", i),
              int'(ba.pellets_left), tbl[i].left);
      chk_opt($sformatf("v%0d.lives", i), int'(ba.lives), tbl[i].lives);
      chk_opt($sformatf("v%0d.fright", i),
              int'(ba.frightened), tbl[i].fr);
      chk_opt($sformatf("v%0d.eaten", i),
              int'(ba.ghost_eaten), tbl[i].ge);
      chk_opt($sformatf("v%0d.respawn", i),
              int'(ba.pac_respawn), tbl[i].rsp);
      chk_opt($sformatf("v%0d.win", i), int'(ba.winOut), tbl[i].win);
      chk_opt($sformatf("v%0d.lose", i), int'(ba.loseOut), tbl[i].lose);
      chk_opt($sformatf("v%0d.pkind", i),
              int'(ba.pellet_kind), tbl[i].pk);
    end
    ba.start = 1'b0;
    ba.ack   = 1'b0;
  endtask

  initial begin
    int n;
    int nz;
    int exp_s;

    // st ak col row gh  score left lives fr ge rsp win lose pk
    v(1,0,1,1,0,    0,4,3, 0,0,0,0,0,0);
    v(0,0,0,0,0,   10,3,3, 0,0,0,0,0,0);
    v(0,0,0,0,0,   10,3,3, 0,0,0,0,0,0);
    v(0,0,1,0,0,   20,2,3, 0,0,0,0,0,0);
    v(0,0,2,0,0,   30,1,3, 0,0,0,0,0,0);
    v(0,0,3,0,0,   80,0,3, 1,0,0,0,0,0);
    v(0,0,1,1,0,   80,0,3,-1,0,0,1,0,0);
    v(0,1,1,1,0,   80,0,3,-1,0,0,0,0,0);
    v(1,0,1,1,0,    0,3,3, 0,0,0,0,0,0);
    v(0,0,0,0,0,   50,2,3, 1,0,0,0,0,0);
    v(0,0,1,1,15, 250,2,3, 1,1,0,0,0,0);
    v(0,0,1,1,15, 650,2,3, 1,2,0,0,0,0);
    v(0,0,1,1,15,1450,2,3, 1,4,0,0,0,0);
    v(0,0,1,1,15,3050,2,3, 1,8,0,0,0,0);
    v(0,0,1,1,15,3050,2,3, 1,0,0,0,0,0);
    v(0,0,1,0,1, 3050,2,2, 0,0,1,0,0,1);
    for (int i = 0; i < 5; i++)
      v(0,0,1,0,1, 3050,2,2, 0,0,0,0,0,1);
    v(0,0,1,0,1, 3050,2,1, 0,0,1,0,0,1);
    for (int i = 0; i < 5; i++)
      v(0,0,1,0,1, 3050,2,1, 0,0,0,0,0,1);
    v(0,0,1,0,1, 3050,2,0, 0,0,1,0,1,1);
    v(1,1,1,1,0, 3050,2,0,-1,0,0,0,0,0);
    v(1,0,1,1,0, 3050,2,0,-1,0,0,0,0,0);
    v(0,0,1,1,0, 3050,2,0,-1,0,0,0,0,0);
    v(1,0,1,1,0,    0,2,3, 0,0,0,0,0,0);
    v(0,0,1,0,0,   10,1,3, 0,0,0,0,0,0);

    {ba.start, ba.ack, ba.init_we} = '0;
    {ba.init_col, ba.init_row, ba.init_kind} = '0;
    {ba.pacX, ba.pacY, ba.hCount, ba.vCount} = '0;
    ba.ghost_hit = '0;
    {bb.start, bb.ack, bb.init_we} = '0;
    {bb.init_col, bb.init_row, bb.init_kind} = '0;
    {bb.pacX, bb.pacY, bb.hCount, bb.vCount} = '0;
    bb.ghost_hit = '0;

    step();
    step();
    chk("rst.score", int'(ba.score), 0);
    chk("rst.lives", int'(ba.lives), 0);
    chk("rst.left", int'(ba.pellets_left), 0);
    chk("rst.flags", int'({ba.frightened, ba.pac_respawn,
                           ba.winOut, ba.loseOut}), 0);
    chk("rst.eaten", int'(ba.ghost_eaten), 0);
    chk("rst.pkind", int'(ba.pellet_kind), 0);
    rst_n = 1'b1;
    step();

    wr_a(0, 0, 1);
    wr_a(1, 0, 1);
    wr_a(2, 0, 1);
    wr_a(3, 0, 2);
    wr_a(0, 0, 1);
    wr_a(1, 1, 3);
    chk("load.left4", int'(ba.pellets_left), 4);
    wr_a(2, 0, 0);
    chk("load.clear", int'(ba.pellets_left), 3);
    wr_a(2, 0, 1);
    chk("load.refill", int'(ba.pellets_left), 4);
    ba.hCount = 10'd53;
    ba.vCount = 10'd3;
    #1;
    chk("load.pk_power", int'(ba.pellet_kind), 2);
    ba.pacX = 10'd21;
    ba.pacY = 10'd19;
    step();
    chk("idle.no_eat", int'(ba.score), 0);
    run(0, 7);

    wr_a(0, 0, 2);
    wr_a(1, 0, 1);
    wr_a(2, 0, 1);
    chk("load2.left", int'(ba.pellets_left), 3);
    run(8, 14);

    ba.ghost_hit = '0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      n++;
      if (!ba.frightened) break;
    end
    chk("fright.len", n, 35);

    run(15, nv - 1);

    rst_n = 1'b0;
    step();
    chk("mrst.score", int'(ba.score), 0);
    chk("mrst.lives", int'(ba.lives), 0);
    chk("mrst.left", int'(ba.pellets_left), 0);
    chk("mrst.flags", int'({ba.frightened, ba.pac_respawn,
                            ba.winOut, ba.loseOut}), 0);
    rst_n = 1'b1;
    step();
    nz = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ba.hCount = 10'(c * 16 + 2);
        ba.vCount = 10'(r * 16 + 2);
        #1;
        if (ba.pellet_kind != 2'd0) nz++;
      end
    chk("mrst.map_empty", nz, 0);
    ba.pacX = 10'd21;
    ba.pacY = 10'd19;
    step();
    chk("mrst.idle", int'(ba.score), 0);

    for (int c = 0; c < 6; c++)
      wr_b(c, 0, 2);
    wr_b(0, 1, 1);
    chk("b.left", int'(bb.pellets_left), 7);
    bb.hCount = 10'd133;
    bb.vCount = 10'd3;
    #1;
    chk("b.pk_oob", int'(bb.pellet_kind), 0);
    bb.hCount = 10'd3;
    bb.vCount = 10'd19;
    #1;
    chk("b.pk_row1", int'(bb.pellet_kind), 1);
    bb.pacX  = 10'd133;
    bb.pacY  = 10'd3;
    bb.start = 1'b1;
    step();
    bb.start = 1'b0;
    chk("b.start_lives", int'(bb.lives), 3);
    step();
    chk("b.oob_score", int'(bb.score), 0);
    chk("b.oob_left", int'(bb.pellets_left), 7);
    for (int c = 0; c < 6; c++) begin
      bb.pacX = 10'(c * 16 + 4);
      step();
      exp_s = (c + 1) * 50;
      if (exp_s > 255) exp_s = 255;
      chk($sformatf("b.sat%0d", c), int'(bb.score), exp_s);
    end
    chk("b.left_end", int'(bb.pellets_left), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pellet_score_engine.md
# pellet_score_engine

Tile-based scoring and game-outcome engine for the Pacman datapath; parametrised successor to the single-pellet-grid scorer. Holds the pellet map internally as a tile grid with two pellet kinds, detects pellet and ghost collisions per clock, and scores them. Manages power-mode (frightened) timing with a ghost-eat combo, a lives counter with a respawn delay, and win/lose handshakes. Sits between the sprite position logic and the VGA renderer; exposes a combinational pellet read port for drawing.

## Interface
Parameters:
- COLS, 40, maze width in tiles
- ROWS, 30, maze height in tiles
- TILE_SHIFT, 4, log2 tile size in pixels (pixel→tile = coordinate >> TILE_SHIFT)
- NUM_GHOSTS, 4, ghost collision channels
- SCORE_W, 16, score width
- PELLET_PTS, 10, normal pellet value
- POWER_PTS, 50, power pellet value
- GHOST_PTS, 200, base ghost value (doubles per combo step)
- POWER_CYCLES, 2**24, frightened duration in clocks
- RESPAWN_CYCLES, 2**23, post-death freeze in clocks
- START_LIVES, 3, lives loaded on start

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin game (sampled in IDLE only)
- ack  in  1  acknowledge WIN/LOSE, return to IDLE
- init_we  in  1  pellet map write strobe (IDLE only)
- init_col  in  $clog2(COLS)  write tile column
- init_row  in  $clog2(ROWS)  write tile row
- init_kind  in  2  0 empty, 1 pellet, 2 power, 3 treated as 0
- pacX, pacY  in  10 each  pacman pixel position
- ghost_hit  in  NUM_GHOSTS  per-ghost overlap level with pacman
- hCount, vCount  in  10 each  render query pixel
- pellet_kind  out  2  combinational kind of tile under (hCount, vCount)
- score  out  SCORE_W  current score
- lives  out  2  remaining lives
- pellets_left  out  12  non-empty tiles remaining
- frightened  out  1  power mode active
- ghost_eaten  out  NUM_GHOSTS  one-cycle pulse per eaten ghost
- pac_respawn  out  1  one-cycle pulse on death
- winOut, loseOut  out  1 each  level while in WIN / LOSE

## Operation
- States: IDLE, PLAY, DYING, WIN, LOSE. Reset → IDLE.
- IDLE: init_we writes the tile; pellets_left +1 when writing non-empty over empty, −1 when writing empty over non-empty, otherwise unchanged. start → PLAY; score←0, lives←START_LIVES, frightened←0, combo←0. Writes in other states are ignored.
- PLAY, per cycle, priority order:
  1. Any ghost_hit with frightened=0 → lives−1, pac_respawn pulse, frightened cleared; lives was 1 → LOSE, else → DYING. No pellet eaten this cycle.
  2. frightened=1 and lowest-index hit ghost i not yet eaten this power period → score += GHOST_PTS<<combo, combo+1 (saturates at 3), ghost_eaten[i] pulse, mark i eaten. Other hit ghosts are handled on following cycles. Already-eaten ghosts are ignored.
  3. Independently of step 2, the tile under (pacX>>TILE_SHIFT, pacY>>TILE_SHIFT) is non-empty → cleared, pellets_left−1, score += PELLET_PTS or POWER_PTS. Power pellet reloads the frightened timer to POWER_CYCLES (restarts if already active), clears combo and the eaten mask.
- Steps 2 and 3 points in the same cycle are both added.
- Score saturates at all ones and never wraps.
- pellets_left reaching 0 → WIN (checked on the registered count, one cycle after the last eat).
- Out-of-range tile (col≥COLS or row≥ROWS): reads return 0, writes and eats are ignored.
- Frightened timer decrements in PLAY only and holds in DYING. At 0, frightened←0 and the eaten mask is cleared.
- DYING: RESPAWN_CYCLES countdown, then → PLAY. All collisions are ignored.
- WIN/LOSE: score frozen; ack → IDLE. The pellet map is retained; the host reloads it.

## Timing
- Reset values: score 0, lives 0, pellets_left 0, frightened 0, ghost_eaten 0, pac_respawn 0, winOut 0, loseOut 0, map all empty, state IDLE.
- All outputs except pellet_kind are registered. Eat/collision effects are visible one clock after the sampling edge.
- pellet_kind is combinational from hCount/vCount and the current map. A cleared tile disappears the cycle after the eat.
- Pacman holding on an eaten tile scores exactly once.
- Reset asserted mid-game forces IDLE on the next edge and clears the map.
- start held through WIN→IDLE does not restart until deasserted and reasserted.

## Test plan
- Load 3 pellets + 1 power, start, walk pacman over all 4 → score 80, pellets_left 0, winOut on the cycle after the last eat; ack → IDLE.
- Eat power pellet, assert ghost_hit on ghosts 0,1,2,3 together → ghost_eaten pulses 0,1,2,3 on consecutive cycles, score +200+400+800+1600.
- ghost_hit with frightened=0, lives=3 → lives 2, pac_respawn pulse, DYING for RESPAWN_CYCLES (small override), then PLAY; repeat to lives=1 hit → loseOut.
- Ghost hit and pellet tile in the same cycle, not frightened → pellet not eaten, pellets_left unchanged.
- SCORE_W=8, score 250, eat power pellet → score 255 (saturates).
- Reset low mid-PLAY → all outputs at reset values; pellet_kind 0 everywhere.
